// File: rtl/st_to_mm_adapter_pkg.sv
// Shared definitions for the ST-to-MM read bridge: the MM address map and
// the bit positions of the fields in the STATUS register.
package st_mm_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_PKTCNT = 2'd2,
    ADDR_RSVD   = 2'd3
  } addr_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_SOP       = 2;
  localparam int ST_EOP       = 3;
  localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/st_to_mm_adapter_if.sv
// Bundles the Avalon-ST sink and Avalon-MM read-slave signals of the bridge.
// The slave modport is the adapter's view; master is the environment's view.
interface st_to_mm_adapter_if #(
  parameter int WIDTH = 8
) ();

  logic             in_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sop;
  logic             in_eop;

  logic             out_read;
  logic [1:0]       out_address;
  logic             out_waitrequest;
  logic [WIDTH-1:0] out_readdata;
  logic             out_readdatavalid;

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_sop, in_eop,
    input  out_read, out_address,
    output out_waitrequest, out_readdata, out_readdatavalid
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, in_sop, in_eop,
    output out_read, out_address,
    input  out_waitrequest, out_readdata, out_readdatavalid
  );

endinterface

// File: rtl/st_to_mm_adapter_fifo.sv
// Synchronous FIFO with registered count and a combinational head-of-queue
// view; no bypass, so a pushed word becomes visible the cycle after the push.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; count gates every read of it,
  // and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/st_to_mm_adapter.sv
// Avalon-ST sink to Avalon-MM read-slave bridge: words are buffered in a FIFO
// and drained by DATA reads. Optional macro ST_TO_MM_PKT_COUNT_EN enables a
// clear-on-read end-of-packet counter at address 2.
module st_to_mm_adapter
  import st_mm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  st_to_mm_adapter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH+1:0] fifo_head;
  logic             head_sop, head_eop;
  logic [WIDTH-1:0] head_data;
  addr_e            addr;
  logic             rd_accept;
  logic [WIDTH-1:0] status_word, pktcnt_word;
  logic [WIDTH-1:0] readdata_d, readdata_q;
  logic             readdatavalid_q;

  assign addr                = addr_e'(bus.out_address);
  assign bus.in_ready        = !fifo_full && reset;
  assign bus.out_waitrequest = (bus.out_read && (addr == ADDR_DATA) && fifo_empty) || !reset;
  assign rd_accept           = bus.out_read && !bus.out_waitrequest;
  assign fifo_push           = bus.in_valid && bus.in_ready;
  assign fifo_pop            = rd_accept && (addr == ADDR_DATA);
  assign {head_sop, head_eop, head_data} = fifo_head;

  sync_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .wdata_i ({bus.in_sop, bus.in_eop, bus.in_data}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Head flags are masked while empty so stale storage never leaks out.
  always_comb begin
    status_word                       = '0;
    status_word[ST_EMPTY]             = fifo_empty;
    status_word[ST_FULL]              = fifo_full;
    status_word[ST_SOP]               = !fifo_empty && head_sop;
    status_word[ST_EOP]               = !fifo_empty && head_eop;
    status_word[ST_COUNT_LSB +: CW]   = fifo_count;
  end

`ifdef ST_TO_MM_PKT_COUNT_EN
  logic [WIDTH-1:0] pktcnt_q, pktcnt_d;
  logic             pkt_inc, pkt_clr;

  assign pkt_inc = fifo_push && bus.in_eop;
  assign pkt_clr = rd_accept && (addr == ADDR_PKTCNT);

  // A read-clear racing an increment keeps the new packet: counter lands on 1.
  always_comb begin
    pktcnt_d = pktcnt_q;
    if (pkt_clr)      pktcnt_d = WIDTH'(pkt_inc);
    else if (pkt_inc) pktcnt_d = pktcnt_q + WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) pktcnt_q <= '0;
    else        pktcnt_q <= pktcnt_d;
  end

  assign pktcnt_word = pktcnt_q;
`else
  assign pktcnt_word = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    readdata_d = '0;
    case (addr)
      ADDR_DATA:   readdata_d = head_data;
      ADDR_STATUS: readdata_d = status_word;
      ADDR_PKTCNT: readdata_d = pktcnt_word;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= rd_accept;
      if (rd_accept) readdata_q <= readdata_d;
    end
  end

  assign bus.out_readdata      = readdata_q;
  assign bus.out_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_st_to_mm_adapter.sv
// Scoreboard bench for st_to_mm_adapter: read expectations are queued with the
// cycle they are due and compared by a negedge monitor.
module tb_st_to_mm_adapter;
  import st_mm_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } rd_exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  rd_exp_t      rd_q[$];
  logic [W+1:0] model_q[$];

  st_to_mm_adapter_if #(.WIDTH(W)) bus ();

  st_to_mm_adapter #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Compares readdatavalid timing and readdata against the scoreboard.
  always @(negedge clock) begin
    logic exp_v;
    exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
    if (exp_v || bus.out_readdatavalid) begin
      checks++;
      if (bus.out_readdatavalid !== exp_v) begin
        errors++;
        $display("FAIL rdv_timing cyc=%0d got=%b exp=%b", cyc, bus.out_readdatavalid, exp_v);
      end else if (bus.out_readdata !== rd_q[0].data) begin
        errors++;
        $display("FAIL readdata cyc=%0d got=%h exp=%h", cyc, bus.out_readdata, rd_q[0].data);
      end
      if (exp_v) void'(rd_q.pop_front());
    end
  end

  function automatic void expect_rd(input logic [W-1:0] d);
    rd_exp_t e;
    e.due  = cyc + 1;
    e.data = d;
    rd_q.push_back(e);
  endfunction

  function automatic logic [W-1:0] model_status();
    logic [W-1:0] s;
    logic [W+1:0] h;
    s = '0;
    s[ST_EMPTY] = (model_q.size() == 0);
    s[ST_FULL]  = (model_q.size() == D);
    if (model_q.size() > 0) begin
      h = model_q[0];
      s[ST_SOP] = h[W+1];
      s[ST_EOP] = h[W];
    end
    s[ST_COUNT_LSB +: CW] = CW'(model_q.size());
    return s;
  endfunction

  task automatic push_word(input logic [W-1:0] d, input logic sop, input logic eop);
    int n = 0;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sop = sop; bus.in_eop = eop;
    #1;
    while (!bus.in_ready && n < 50) begin @(negedge clock); #1; n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout data=%h in_ready=%b required=1", d, bus.in_ready);
    end else begin
      model_q.push_back({sop, eop, d});
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
  endtask

  task automatic mm_read(input logic [1:0] a, input logic [W-1:0] exp);
    int n = 0;
    @(negedge clock);
    bus.out_read = 1'b1; bus.out_address = a;
    #1;
    while (bus.out_waitrequest && n < 50) begin @(negedge clock); #1; n++; end
    if (bus.out_waitrequest) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%0d waitrequest=%b required=0", a, bus.out_waitrequest);
    end else begin
      expect_rd(exp);
    end
    @(posedge clock); #1;
    bus.out_read = 1'b0;
  endtask

  task automatic read_data();
    logic [W+1:0] e;
    e = model_q.pop_front();
    mm_read(ADDR_DATA, e[W-1:0]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq got=%b exp=1", bus.out_waitrequest); end
    checks++; if (bus.out_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv got=%b exp=0", bus.out_readdatavalid); end
    checks++; if (bus.out_readdata !== 8'h00) begin errors++; $display("FAIL rst_readdata got=%h exp=00", bus.out_readdata); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_waitrequest !== 1'b0) begin errors++; $display("FAIL rel_waitreq got=%b exp=0", bus.out_waitrequest); end
    mm_read(ADDR_STATUS, 8'h01);
  endtask

  task automatic test_single_word();
    push_word(8'hA5, 1'b1, 1'b0);
    mm_read(ADDR_STATUS, 8'h14);
    read_data();
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (bus.out_readdata !== 8'hA5 || bus.out_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL readdata_hold got=%h/%b exp=a5/0", bus.out_readdata, bus.out_readdatavalid);
    end
    mm_read(ADDR_STATUS, 8'h01);
  endtask

  task automatic test_stall_on_empty();
    @(negedge clock);
    bus.out_read = 1'b1; bus.out_address = ADDR_DATA;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.out_waitrequest !== 1'b1) begin
        errors++; $display("FAIL stall_waitreq cycle=%0d got=%b exp=1", i, bus.out_waitrequest);
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    #1;
    checks++;
    if (bus.out_waitrequest !== 1'b1) begin
      errors++; $display("FAIL stall_no_bypass got=%b exp=1", bus.out_waitrequest);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (bus.out_waitrequest !== 1'b0) begin
      errors++; $display("FAIL stall_release got=%b exp=0", bus.out_waitrequest);
    end
    expect_rd(8'h3C);
    @(posedge clock); #1;
    bus.out_read = 1'b0;
  endtask

  task automatic test_full_and_wrap();
    for (int i = 1; i <= 4; i++) push_word(W'(i), 1'b0, 1'b0);
    @(negedge clock); #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 8'h05;
    mm_read(ADDR_STATUS, 8'h42);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_holdoff got=%b exp=0", bus.in_ready); end
    read_data();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got=%b exp=1", bus.in_ready); end
    model_q.push_back({2'b00, 8'h05});
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL refull_in_ready got=%b exp=0", bus.in_ready); end
    mm_read(ADDR_STATUS, model_status());
    repeat (4) read_data();
    mm_read(ADDR_STATUS, 8'h01);
  endtask

  task automatic test_concurrent_and_reset();
    logic [W+1:0] e;
    push_word(8'h11, 1'b1, 1'b0);
    push_word(8'h22, 1'b0, 1'b0);
    mm_read(ADDR_STATUS, 8'h24);
    @(negedge clock);
    bus.out_read = 1'b1; bus.out_address = ADDR_DATA;
    bus.in_valid = 1'b1; bus.in_data = 8'h33; bus.in_eop = 1'b1;
    #1;
    checks++;
    if (bus.out_waitrequest !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL concurrent_hs wait=%b ready=%b exp=0/1", bus.out_waitrequest, bus.in_ready);
    end
    e = model_q.pop_front();
    expect_rd(e[W-1:0]);
    model_q.push_back({2'b01, 8'h33});
    @(posedge clock); #1;
    bus.out_read = 1'b0; bus.in_valid = 1'b0; bus.in_eop = 1'b0;
    mm_read(ADDR_STATUS, 8'h20);
    // Accept a DATA read, then assert reset while its readdatavalid is showing.
    @(negedge clock);
    bus.out_read = 1'b1; bus.out_address = ADDR_DATA;
    #1;
    e = model_q.pop_front();
    expect_rd(e[W-1:0]);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (bus.out_readdatavalid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL midreset rdv=%b ready=%b wait=%b exp=0/0/1",
               bus.out_readdatavalid, bus.in_ready, bus.out_waitrequest);
    end
    bus.out_read = 1'b0;
    reset = 1'b1;
    model_q.delete();
    mm_read(ADDR_STATUS, 8'h01);
  endtask

  task automatic test_pktcnt();
`ifdef ST_TO_MM_PKT_COUNT_EN
    push_word(8'hA1, 1'b1, 1'b0);
    push_word(8'hA2, 1'b0, 1'b1);
    push_word(8'hB1, 1'b1, 1'b1);
    push_word(8'hC1, 1'b1, 1'b1);
    mm_read(ADDR_PKTCNT, 8'd3);
    mm_read(ADDR_PKTCNT, 8'd0);
    repeat (4) read_data();
    @(negedge clock);
    bus.out_read = 1'b1; bus.out_address = ADDR_PKTCNT;
    bus.in_valid = 1'b1; bus.in_data = 8'hD1; bus.in_sop = 1'b1; bus.in_eop = 1'b1;
    #1;
    checks++;
    if (bus.out_waitrequest !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL pkt_race_hs wait=%b ready=%b exp=0/1", bus.out_waitrequest, bus.in_ready);
    end
    expect_rd(8'd0);
    model_q.push_back({2'b11, 8'hD1});
    @(posedge clock); #1;
    bus.out_read = 1'b0; bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    mm_read(ADDR_PKTCNT, 8'd1);
    mm_read(ADDR_PKTCNT, 8'd0);
    read_data();
`else
    push_word(8'hE1, 1'b1, 1'b1);
    mm_read(ADDR_PKTCNT, 8'd0);
    read_data();
`endif
    mm_read(ADDR_RSVD, 8'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.out_read = 1'b0; bus.out_address = '0;
    test_reset();
    test_single_word();
    test_stall_on_empty();
    test_full_and_wrap();
    test_concurrent_and_reset();
    test_pktcnt();
    repeat (3) @(negedge clock);
    checks++;
    if (rd_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain pending=%0d exp=0", rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
